// File: rtl/vrased_pkg.sv
// Shared definitions for the vrased monitor and its downstream reset sequencer.
// State encodings are plain localparams so other blocks and benches can compare against them.
package vrased_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WIPE = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    localparam int VIOL_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [VIOL_CNT_W-1:0] sat_inc(input logic [VIOL_CNT_W-1:0] v);
        return (v == '1) ? v : v + VIOL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vrased_reset_seq.sv
// Secure reset sequencer: on power-on or a vrased violation, zero the protected RAM
// one word per cycle, hold the CPU in reset a few more cycles, then release it.
module vrased_reset_seq
    import vrased_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 37,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  viol_reset,
    output logic                  cpu_rst,
    output logic                  clr_ram,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  wipe_done,
    output logic [VIOL_CNT_W-1:0] viol_count,
    output logic [1:0]            dbg_state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [VIOL_CNT_W-1:0]   cnt_q;
    logic                    done_q;
    logic                    accept;

    // A violation is only taken outside WIPE: a running wipe already covers it.
    assign accept = viol_reset && ((state_q == ST_IDLE) || (state_q == ST_HOLD));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WIPE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (viol_reset) state_d = ST_WIPE;
            end
            ST_WIPE: begin
                if (addr_q == ADDR_LAST) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (viol_reset)               state_d = ST_WIPE;
                else if (hold_q == HOLD_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_WIPE;
        endcase
    end

    // Address and hold counters sit at zero outside their own state, so every
    // entry into WIPE or HOLD starts from zero without an explicit load.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            hold_q <= '0;
        end else begin
            addr_q <= (state_q == ST_WIPE) ? addr_q + 1'b1 : '0;
            hold_q <= (state_q == ST_HOLD) ? hold_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
            if (accept) cnt_q <= sat_inc(cnt_q);
        end
    end

    // Moore outputs
    always_comb begin
        cpu_rst    = 1'b0;
        clr_ram    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        wipe_done  = done_q;
        viol_count = cnt_q;
        dbg_state  = state_q;
        case (state_q)
            ST_WIPE: begin
                cpu_rst  = 1'b1;
                clr_ram  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
                busy     = 1'b1;
            end
            ST_HOLD: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
            end
            ST_IDLE: begin
                cpu_rst = 1'b0;
            end
            default: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq with a RAM model and expected-address queue.
module tb_vrased_reset_seq;
    import vrased_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 37;
    localparam int HC    = 4;
    localparam int DEPTH = 256;
    localparam int SEQ   = DEPTH + HC;

    logic            clk = 1'b0;
    logic            reset;
    logic            viol_reset;
    logic            cpu_rst;
    logic            clr_ram;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            busy;
    logic            wipe_done;
    logic [7:0]      viol_count;
    logic [1:0]      dbg_state;

    int vectors = 0;
    int errors  = 0;

    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] ram[DEPTH];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    vrased_reset_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .viol_reset(viol_reset),
        .cpu_rst(cpu_rst), .clr_ram(clr_ram), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .wipe_done(wipe_done), .viol_count(viol_count), .dbg_state(dbg_state)
    );

    always @(posedge clk) if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dirty_ram();
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'({$urandom(), $urandom()}) | DW'(1);
    endtask

    task automatic ram_zero_check(input string tag);
        int nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== '0) nz++;
        check_val({tag, "_ram_nonzero"}, nz, 0);
    endtask

    // Starts in a WIPE cycle at addr 0 and follows the sequence until cpu_rst drops.
    task automatic run_seq(input int pulse_addr, input string tag);
        int rst_cyc = 0;
        int bad = 0;
        int done_early = 0;
        logic [AW-1:0] a;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(AW'(i));
        while (cpu_rst === 1'b1 && rst_cyc < 2 * SEQ) begin
            rst_cyc++;
            if (wipe_done !== 1'b0) done_early++;
            if (busy !== 1'b1 || clr_ram !== mem_we || mem_wdata !== '0) bad++;
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) bad++;
                else begin
                    a = exp_q.pop_front();
                    if (mem_addr !== a) bad++;
                end
                if (dbg_state !== ST_WIPE) bad++;
            end else if (dbg_state !== ST_HOLD || mem_addr !== '0) begin
                bad++;
            end
            viol_reset = (mem_we === 1'b1) && (int'(mem_addr) == pulse_addr);
            tick();
        end
        viol_reset = 1'b0;
        check_val({tag, "_rst_cycles"}, rst_cyc, SEQ);
        check_val({tag, "_wipe_left"}, exp_q.size(), 0);
        check_val({tag, "_seq_outputs"}, bad, 0);
        check_val({tag, "_done_early"}, done_early, 0);
        check_val({tag, "_done_pulse"}, wipe_done, 1);
        check_val({tag, "_idle_ctl"}, {cpu_rst, clr_ram, mem_we, busy}, 4'b0000);
        check_val({tag, "_idle_addr"}, mem_addr, 0);
        check_val({tag, "_idle_state"}, dbg_state, ST_IDLE);
        tick();
        check_val({tag, "_done_clear"}, wipe_done, 0);
    endtask

    initial begin
        int h;
        int guard;
        int drops;
        int r;

        // 1: power-on
        reset = 1'b1;
        viol_reset = 1'b0;
        dirty_ram();
        tick();
        tick();
        check_val("por_cpu_rst", cpu_rst, 1);
        check_val("por_clr_ram", clr_ram, 1);
        check_val("por_mem_we", mem_we, 1);
        check_val("por_addr", mem_addr, 0);
        check_val("por_busy", busy, 1);
        check_val("por_done", wipe_done, 0);
        check_val("por_count", viol_count, 0);
        reset = 1'b0;
        run_seq(-1, "por");
        ram_zero_check("por");
        check_val("por_count_end", viol_count, 0);

        // 2: single-cycle violation in IDLE; output must not react before the edge
        dirty_ram();
        viol_reset = 1'b1;
        #2;
        check_val("no_comb_cpu_rst", cpu_rst, 0);
        check_val("no_comb_busy", busy, 0);
        tick();
        viol_reset = 1'b0;
        check_val("single_cpu_rst", cpu_rst, 1);
        check_val("single_clr_ram", clr_ram, 1);
        check_val("single_addr", mem_addr, 0);
        check_val("single_count", viol_count, 1);
        run_seq(-1, "single");
        ram_zero_check("single");

        // 3: violation during WIPE at 0x80 is ignored
        viol_reset = 1'b1;
        tick();
        viol_reset = 1'b0;
        check_val("midwipe_count_in", viol_count, 2);
        run_seq(128, "midwipe");
        check_val("midwipe_count_out", viol_count, 2);

        // 4: violation in third HOLD cycle restarts the wipe
        viol_reset = 1'b1;
        tick();
        viol_reset = 1'b0;
        h = 0;
        guard = 0;
        while (guard < 1000) begin
            if (dbg_state === ST_HOLD) begin
                if (h == 2) break;
                h++;
            end
            tick();
            guard++;
        end
        check_val("hold_reached", h, 2);
        viol_reset = 1'b1;
        tick();
        viol_reset = 1'b0;
        check_val("hold_restart_state", dbg_state, ST_WIPE);
        check_val("hold_restart_addr", mem_addr, 0);
        check_val("hold_restart_we", mem_we, 1);
        check_val("hold_restart_count", viol_count, 4);
        check_val("hold_restart_done", wipe_done, 0);
        run_seq(-1, "hold_restart");

        // 5: violation held for 600 edges -> entries at edges 0, 257, 514
        viol_reset = 1'b1;
        drops = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (cpu_rst !== 1'b1) drops++;
        end
        viol_reset = 1'b0;
        check_val("held_drops", drops, 0);
        check_val("held_count", viol_count, 7);
        r = 0;
        while (cpu_rst === 1'b1 && r < 1000) begin
            r++;
            tick();
        end
        check_val("held_tail", r, 175);
        check_val("held_done", wipe_done, 1);
        tick();

        // 6: reset mid-wipe, then saturation
        viol_reset = 1'b1;
        tick();
        viol_reset = 1'b0;
        check_val("rstmid_count_in", viol_count, 8);
        guard = 0;
        while (mem_addr !== 8'h40 && guard < 1000) begin
            tick();
            guard++;
        end
        check_val("rstmid_reached", mem_addr, 8'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rstmid_addr", mem_addr, 0);
        check_val("rstmid_count", viol_count, 0);
        check_val("rstmid_state", dbg_state, ST_WIPE);
        run_seq(-1, "rstmid");

        viol_reset = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (e == 1)   check_val("sat_1", viol_count, 1);
            if (e == 254) check_val("sat_254", viol_count, 254);
            if (e == 255) check_val("sat_255", viol_count, 255);
            if (e == 256) check_val("sat_256", viol_count, 255);
            if (e == 300) check_val("sat_300", viol_count, 255);
            for (int k = 0; k < DEPTH; k++) tick();
        end
        viol_reset = 1'b0;
        r = 0;
        while (cpu_rst === 1'b1 && r < 1000) begin
            r++;
            tick();
        end
        check_val("sat_tail", r, HC);
        check_val("sat_final_count", viol_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
